// File: rtl/vga_write_scheduler_pkg.sv
// Shared types and widths for the VgaBuffer write scheduler.
package vga_write_scheduler_pkg;

  localparam int unsigned H_BITS    = 10;
  localparam int unsigned V_BITS    = 9;
  localparam int unsigned BYTE_BITS = 8;

  // One pixel write: coordinate plus colour byte.
  typedef struct packed {
    logic [H_BITS-1:0]    x;
    logic [V_BITS-1:0]    y;
    logic [BYTE_BITS-1:0] px_byte;
  } vga_px_wr_t;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_CLEAR = 1'b1
  } vga_sched_state_t;

endpackage

// File: rtl/vga_write_scheduler_if.sv
// Draw-request valid/ready link from the motor-to-pixel logic.
interface vga_write_scheduler_if;
  import vga_write_scheduler_pkg::*;

  logic                 draw_valid;
  logic                 draw_ready;
  logic [H_BITS-1:0]    draw_x;
  logic [V_BITS-1:0]    draw_y;
  logic [BYTE_BITS-1:0] draw_byte;

  modport master (
    output draw_valid, draw_x, draw_y, draw_byte,
    input  draw_ready
  );

  modport slave (
    input  draw_valid, draw_x, draw_y, draw_byte,
    output draw_ready
  );
endinterface

// File: rtl/vga_write_scheduler_fifo.sv
// Small synchronous FIFO of pending pixel writes with a one-cycle flush.
module vga_write_scheduler_fifo
  import vga_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  vga_px_wr_t din,
  output vga_px_wr_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  vga_px_wr_t    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_write_scheduler.sv
// Arbitrates the VgaBuffer write port between the screen-clear sweep and buffered pen draws.
module vga_write_scheduler
  import vga_write_scheduler_pkg::*;
#(
  parameter int unsigned          H_RES      = 640,
  parameter int unsigned          V_RES      = 480,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [BYTE_BITS-1:0] CLEAR_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 clear_screen,
  vga_write_scheduler_if.slave draw,
  output logic                 wr_en,
  output logic [H_BITS-1:0]    wr_x,
  output logic [V_BITS-1:0]    wr_y,
  output logic [BYTE_BITS-1:0] byte_out,
  output logic                 busy,
  output logic                 clear_done
);

  localparam logic [H_BITS-1:0] X_LAST = H_BITS'(H_RES - 1);
  localparam logic [V_BITS-1:0] Y_LAST = V_BITS'(V_RES - 1);

  vga_sched_state_t  state;
  logic [H_BITS-1:0] sweep_x;
  logic [V_BITS-1:0] sweep_y;
  logic              done_pend;

  vga_px_wr_t        fifo_din;
  vga_px_wr_t        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              flush_c;
  logic              pop_c;
  logic              push_c;

  logic [H_BITS-1:0] cur_x;
  logic [V_BITS-1:0] cur_y;
  logic              sweep_last;

  // FIFO control: a clear command in IDLE flushes and drops any same-cycle push.
  assign flush_c = clk_en && (state == SCHED_IDLE) && clear_screen;
  assign pop_c   = clk_en && (state == SCHED_IDLE) && !clear_screen && !fifo_empty;
  assign push_c  = clk_en && draw.draw_valid && !fifo_full && !flush_c;
  assign draw.draw_ready = !fifo_full;
  assign fifo_din = '{x: draw.draw_x, y: draw.draw_y, px_byte: draw.draw_byte};

  // Pixel the sweep writes this cycle; a re-issued clear restarts it from the origin.
  assign cur_x      = clear_screen ? '0 : sweep_x;
  assign cur_y      = clear_screen ? '0 : sweep_y;
  assign sweep_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

  vga_write_scheduler_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scheduler FSM, sweep counters and registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCHED_IDLE;
      sweep_x    <= '0;
      sweep_y    <= '0;
      done_pend  <= 1'b0;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      byte_out   <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      clear_done <= 1'b0;
      busy       <= (state == SCHED_CLEAR);
      if (clk_en) begin
        case (state)
          SCHED_IDLE: begin
            if (done_pend) begin
              clear_done <= 1'b1;
              done_pend  <= 1'b0;
            end
            if (clear_screen) begin
              state   <= SCHED_CLEAR;
              sweep_x <= '0;
              sweep_y <= '0;
            end else if (!fifo_empty) begin
              wr_en    <= 1'b1;
              wr_x     <= fifo_head.x;
              wr_y     <= fifo_head.y;
              byte_out <= fifo_head.px_byte;
            end
          end
          SCHED_CLEAR: begin
            wr_en    <= 1'b1;
            wr_x     <= cur_x;
            wr_y     <= cur_y;
            byte_out <= CLEAR_BYTE;
            if (sweep_last) begin
              state     <= SCHED_IDLE;
              done_pend <= 1'b1;
              sweep_x   <= '0;
              sweep_y   <= '0;
            end else if (cur_x == X_LAST) begin
              sweep_x <= '0;
              sweep_y <= cur_y + V_BITS'(1);
            end else begin
              sweep_x <= cur_x + H_BITS'(1);
              sweep_y <= cur_y;
            end
          end
          default: state <= SCHED_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Randomized self-checking bench for vga_write_scheduler against a queue-based reference.
module tb_vga_write_scheduler;
  import vga_write_scheduler_pkg::*;

  localparam int H = 4;
  localparam int V = 3;
  localparam int NPIX = H * V;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 clear_screen = 1'b0;
  logic                 wr_en;
  logic [H_BITS-1:0]    wr_x;
  logic [V_BITS-1:0]    wr_y;
  logic [BYTE_BITS-1:0] byte_out;
  logic                 busy;
  logic                 clear_done;

  vga_write_scheduler_if dif ();

  vga_write_scheduler #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (4),
    .CLEAR_BYTE (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .clear_screen (clear_screen),
    .draw         (dif),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .byte_out     (byte_out),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  vga_px_wr_t obs_q[$];
  logic       obs_busy[$];
  vga_px_wr_t exp_q[$];
  int         done_cnt = 0;
  time        last_wr_t = 0;
  time        last_done_t = 0;

  // Observer: every write the DUT issues and every clear_done pulse.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back('{x: wr_x, y: wr_y, px_byte: byte_out});
      obs_busy.push_back(busy);
      last_wr_t = $time;
    end
    if (clear_done === 1'b1) begin
      done_cnt++;
      last_done_t = $time;
    end
  end

  // Reference: the i-th pixel of a raster sweep, row-major.
  function automatic vga_px_wr_t clr_px(int i);
    vga_px_wr_t p;
    p.x = H_BITS'(i % H);
    p.y = V_BITS'(i / H);
    p.px_byte = 8'h00;
    return p;
  endfunction

  function automatic vga_px_wr_t rand_px();
    vga_px_wr_t p;
    p.x = H_BITS'($urandom_range(0, 1023));
    p.y = V_BITS'($urandom_range(0, 511));
    p.px_byte = BYTE_BITS'($urandom_range(1, 255));
    return p;
  endfunction

  task automatic reset_obs();
    obs_q.delete();
    obs_busy.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_clear();
    clear_screen = 1'b1;
    @(posedge clk); #1;
    clear_screen = 1'b0;
  endtask

  task automatic wait_done(int target, int budget);
    for (int t = 0; t < budget; t++) begin
      if (done_cnt >= target) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Present one draw request and hold it until the handshake completes.
  task automatic push_draw(input vga_px_wr_t p, input string name);
    logic rdy;
    logic ok;
    ok = 1'b0;
    dif.draw_valid = 1'b1;
    dif.draw_x = p.x;
    dif.draw_y = p.y;
    dif.draw_byte = p.px_byte;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = dif.draw_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    dif.draw_valid = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept: got %b expected 1 within 200 cycles", name, ok);
    end
  endtask

  task automatic compare_obs(input string name);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d writes expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s write[%0d]: got (%0d,%0d,%02h) expected (%0d,%0d,%02h)", name, i,
                 obs_q[i].x, obs_q[i].y, obs_q[i].px_byte, exp_q[i].x, exp_q[i].y, exp_q[i].px_byte);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_en, wr_x, wr_y, byte_out, busy, clear_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b x=%0d y=%0d b=%02h busy=%b done=%b expected all 0",
               wr_en, wr_x, wr_y, byte_out, busy, clear_done);
    end
    n_cmp++;
    if (dif.draw_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b expected 1", dif.draw_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_draw_latency();
    vga_px_wr_t p;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) p = '{x: 10'd5, y: 9'd2, px_byte: 8'hE0};
      else p = rand_px();
      dif.draw_valid = 1'b1;
      dif.draw_x = p.x;
      dif.draw_y = p.y;
      dif.draw_byte = p.px_byte;
      @(posedge clk); #1;
      dif.draw_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wr_en !== 1'b0) begin
        n_bad++;
        $display("FAIL latency_n1[%0d]: got wr_en=%b expected 0", k, wr_en);
      end
      @(negedge clk);
      n_cmp++;
      if ({wr_en, wr_x, wr_y, byte_out} !== {1'b1, p.x, p.y, p.px_byte}) begin
        n_bad++;
        $display("FAIL latency_n2[%0d]: got en=%b (%0d,%0d,%02h) expected en=1 (%0d,%0d,%02h)",
                 k, wr_en, wr_x, wr_y, byte_out, p.x, p.y, p.px_byte);
      end
      @(negedge clk);
      n_cmp++;
      if (wr_en !== 1'b0) begin
        n_bad++;
        $display("FAIL latency_n3[%0d]: got wr_en=%b expected 0", k, wr_en);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear();
    reset_obs();
    pulse_clear();
    wait_done(1, 100);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    compare_obs("clear");
    for (int i = 0; i < obs_busy.size(); i++) begin
      n_cmp++;
      if (obs_busy[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL clear_busy[%0d]: got %b expected 1", i, obs_busy[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL clear_done_count: got %0d expected 1", done_cnt);
    end
    n_cmp++;
    if (!(last_done_t > last_wr_t)) begin
      n_bad++;
      $display("FAIL clear_done_order: got done@%0t last write@%0t expected done later", last_done_t, last_wr_t);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_clear_with_draws();
    vga_px_wr_t dr[6];
    reset_obs();
    for (int k = 0; k < 6; k++) dr[k] = rand_px();
    pulse_clear();
    for (int k = 0; k < 4; k++) push_draw(dr[k], "clear_draw");
    @(negedge clk);
    n_cmp++;
    if ({dif.draw_ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL fifo_full_stall: got ready=%b busy=%b expected ready=0 busy=1", dif.draw_ready, busy);
    end
    @(posedge clk); #1;
    push_draw(dr[4], "late_draw");
    push_draw(dr[5], "late_draw");
    for (int t = 0; t < 200 && obs_q.size() < NPIX + 6; t++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    for (int k = 0; k < 6; k++) exp_q.push_back(dr[k]);
    compare_obs("clear_then_drain");
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL drain_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_restart();
    logic found;
    reset_obs();
    found = 1'b0;
    pulse_clear();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_x == 10'd1 && wr_y == 9'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_reach: got %b expected 1", found);
    end
    clear_screen = 1'b1;
    @(posedge clk); #1;
    clear_screen = 1'b0;
    wait_done(1, 100);
    for (int i = 0; i < 6; i++) exp_q.push_back(clr_px(i));
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    compare_obs("restart");
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_flush();
    vga_px_wr_t p;
    logic found;
    reset_obs();
    found = 1'b0;
    pulse_clear();
    push_draw(rand_px(), "flush_q");
    push_draw(rand_px(), "flush_q");
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_x == 10'(H - 1) && wr_y == 9'(V - 1)) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_reach: got %b expected 1", found);
    end
    p = rand_px();
    clear_screen = 1'b1;
    dif.draw_valid = 1'b1;
    dif.draw_x = p.x;
    dif.draw_y = p.y;
    dif.draw_byte = p.px_byte;
    @(posedge clk); #1;
    clear_screen = 1'b0;
    dif.draw_valid = 1'b0;
    wait_done(2, 100);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    compare_obs("flush");
    n_cmp++;
    if (done_cnt !== 2) begin
      n_bad++;
      $display("FAIL flush_done_count: got %0d expected 2", done_cnt);
    end
  endtask

  task automatic test_clk_en_and_reset();
    int   viol;
    logic en;
    reset_obs();
    viol = 0;
    pulse_clear();
    @(negedge clk);
    for (int t = 0; t < 400 && done_cnt == 0; t++) begin
      en = 1'($urandom_range(0, 1));
      clk_en = en;
      @(posedge clk);
      @(negedge clk);
      if (wr_en === 1'b1 && en !== 1'b1) viol++;
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL clk_en_gating: got %0d writes on disabled cycles expected 0", viol);
    end
    for (int i = 0; i < NPIX; i++) exp_q.push_back(clr_px(i));
    compare_obs("clk_en_clear");
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL clk_en_done_count: got %0d expected 1", done_cnt);
    end

    reset_obs();
    pulse_clear();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({wr_en, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL midsweep_active: got en=%b busy=%b expected 1 1", wr_en, busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, wr_x, wr_y, byte_out, busy, clear_done} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got en=%b x=%0d y=%0d b=%02h busy=%b done=%b expected all 0",
               wr_en, wr_x, wr_y, byte_out, busy, clear_done);
    end
    @(negedge clk);
    reset = 1'b1;
    reset_obs();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if ({32'(obs_q.size()), 32'(done_cnt), busy} !== 65'd0) begin
      n_bad++;
      $display("FAIL no_resume: got writes=%0d done=%0d busy=%b expected 0 0 0", obs_q.size(), done_cnt, busy);
    end
  endtask

  initial begin
    dif.draw_valid = 1'b0;
    dif.draw_x = '0;
    dif.draw_y = '0;
    dif.draw_byte = '0;
    test_reset();
    test_draw_latency();
    test_clear();
    test_clear_with_draws();
    test_restart();
    test_flush();
    test_clk_en_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
